tft_pixel_feeder: RTL

TFT_PIXEL_FEEDER -- requirements
Module: tft_pixel_feeder

---
 rtl/tft_pixel_feeder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/tft_pixel_feeder.sv
// Prefetches RGB565 pixels from frame RAM into a 2-entry FIFO and presents them to a TFT driver.
// Optional build macro TFT_FEEDER_TESTPATTERN_EN adds pattern_sel and an internal 8-bar colour source.
module tft_pixel_feeder #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fb_clk,
`ifdef TFT_FEEDER_TESTPATTERN_EN
    input  logic              pattern_sel,
`endif
    output logic [15:0]       pixel_data,
    output logic              data_ready,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [15:0]       ram_rdata,
    output logic              frame_start,
    output logic              underrun
);

    localparam int unsigned       NPIX      = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    logic              fb_clk_q;
    logic              consume;
    logic [1:0]        count;
    logic [15:0]       head_q;
    logic [15:0]       tail_q;
    logic              rd_pending;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        slots_used;
    logic              issue;
    logic              push;
    logic              pop;
    logic [15:0]       push_data;

    assign consume = fb_clk_q & ~fb_clk;
    assign pop     = consume && (count != 2'd0);
    assign push    = rd_pending;

    // A pop only frees its slot once count has updated, so count is used as registered.
    assign slots_used = {1'b0, count} + {2'b00, rd_pending};
    assign issue      = !rst && enable && (slots_used < 3'd2);

    assign data_ready  = (count != 2'd0);
    assign pixel_data  = head_q;
    assign ram_addr    = addr_q;
    assign frame_start = issue && (addr_q == '0);

`ifdef TFT_FEEDER_TESTPATTERN_EN
    localparam int             XW     = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam logic [XW-1:0]  X_LAST = XW'(H_RES - 1);

    logic [XW-1:0] x_q;
    logic [2:0]    bar_idx;
    logic [15:0]   bar_colour;
    logic [15:0]   pat_q;
    logic          pat_sel_q;

    assign bar_idx = 3'((32'(x_q) * 32'd8) / 32'(H_RES));

    always_comb begin
        bar_colour = 16'h0000;
        case (bar_idx)
            3'd0:    bar_colour = 16'hFFFF;
            3'd1:    bar_colour = 16'hFFE0;
            3'd2:    bar_colour = 16'h07FF;
            3'd3:    bar_colour = 16'h07E0;
            3'd4:    bar_colour = 16'hF81F;
            3'd5:    bar_colour = 16'hF800;
            3'd6:    bar_colour = 16'h001F;
            default: bar_colour = 16'h0000;
        endcase
    end

    // Pattern reads follow the same issue/push cadence as RAM reads, just without the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            pat_q     <= 16'h0000;
            pat_sel_q <= 1'b0;
        end else if (issue) begin
            x_q       <= (x_q == X_LAST || addr_q == LAST_ADDR) ? '0 : x_q + XW'(1);
            pat_q     <= bar_colour;
            pat_sel_q <= pattern_sel;
        end
    end

    assign ram_rd    = issue && !pattern_sel;
    assign push_data = pat_sel_q ? pat_q : ram_rdata;
`else
    assign ram_rd    = issue;
    assign push_data = ram_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_clk_q   <= 1'b0;
            count      <= 2'd0;
            head_q     <= 16'h0000;
            tail_q     <= 16'h0000;
            rd_pending <= 1'b0;
            addr_q     <= '0;
            underrun   <= 1'b0;
        end else begin
            fb_clk_q   <= fb_clk;
            rd_pending <= issue;
            if (issue) begin
                addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
            end
            if (consume && (count == 2'd0)) begin
                underrun <= 1'b1;
            end
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_q <= push_data;
                    end else begin
                        tail_q <= push_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    // Head is left untouched when the last entry leaves, keeping pixel_data stable.
                    if (count == 2'd2) begin
                        head_q <= tail_q;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= push_data;
                    end else begin
                        head_q <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
